// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the 32-bit LSU to 16-bit async SRAM bridge.
package sram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_bridge_32b.sv
// Splits one byte-masked 32-bit request into up to two timed 16-bit accesses on an
// IS61WV25616 SRAM, low halfword first, then pulses o_ack with the assembled read data.
module sram_bridge_32b
    import sram_bridge_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int ADDR_W      = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_bmask,
    input  logic              i_wren,
    input  logic              i_rden,
    output logic [31:0]       o_rdata,
    output logic              o_ack,
    output logic [1:0]        o_state,
    output logic [17:0]       SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam int         WORD_W   = ADDR_W - 2;

    // Handshake: a level request (i_wren/i_rden) is taken only while IDLE; o_ack
    // is a single-cycle completion strobe and the client drops its request on it.
    state_t            r_state, w_nxt_state;
    logic [3:0]        r_cnt, w_nxt_cnt;
    logic [WORD_W-1:0] r_word;
    logic [31:0]       r_wdata, r_rbuf, r_rdata;
    logic [3:0]        r_bmask;
    logic              r_wr, r_ack, r_dq_oe;
    logic [15:0]       r_dq_out;
    logic [17:0]       r_sram_addr;
    logic              r_ce_n, r_we_n, r_oe_n, r_lb_n, r_ub_n;

    logic              w_accept, w_wr, w_phase, w_half, w_cur_phase, w_rd_sample;
    logic [WORD_W-1:0] w_word;
    logic [31:0]       w_wdata, w_nxt_rbuf, w_nxt_rdata;
    logic [3:0]        w_bmask;
    logic [1:0]        w_half_mask;
    logic [15:0]       w_rd_half, w_nxt_dq_out;
    logic [17:0]       w_nxt_addr;
    logic              w_nxt_dq_oe, w_nxt_ack;
    logic              w_unused_addr;

    assign w_unused_addr = ^i_addr[1:0];
    assign w_accept      = (r_state == IDLE) && (i_wren || i_rden);

    // In IDLE the outgoing request is still on the inputs; afterwards use the captured copy.
    assign w_word  = (r_state == IDLE) ? i_addr[ADDR_W-1:2] : r_word;
    assign w_wdata = (r_state == IDLE) ? i_wdata : r_wdata;
    assign w_bmask = (r_state == IDLE) ? i_bmask : r_bmask;
    assign w_wr    = (r_state == IDLE) ? i_wren  : r_wr;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_wdata <= '0;
            r_bmask <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if (w_accept) begin
                r_word  <= i_addr[ADDR_W-1:2];
                r_wdata <= i_wdata;
                r_bmask <= i_bmask;
                r_wr    <= i_wren;
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nxt_cnt = CNT_LOAD;
                    if (|i_bmask[1:0])      w_nxt_state = LO;
                    else if (|i_bmask[3:2]) w_nxt_state = HI;
                    else                    w_nxt_state = ACK;
                end
            end
            LO: begin
                if (r_cnt == 4'd0) begin
                    w_nxt_cnt   = CNT_LOAD;
                    w_nxt_state = (|r_bmask[3:2]) ? HI : ACK;
                end else begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end
            end
            HI: begin
                if (r_cnt == 4'd0) w_nxt_state = ACK;
                else               w_nxt_cnt   = r_cnt - 4'd1;
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_comb begin
        w_phase     = (w_nxt_state == LO) || (w_nxt_state == HI);
        w_half      = (w_nxt_state == HI) ? HALF_HI : HALF_LO;
        w_half_mask = (w_half == HALF_HI) ? w_bmask[3:2] : w_bmask[1:0];
        w_cur_phase = (r_state == LO) || (r_state == HI);

        w_nxt_addr   = r_sram_addr;
        w_nxt_dq_out = r_dq_out;
        if (w_phase) w_nxt_addr = 18'({w_word, w_half});
        if (w_phase && w_wr) w_nxt_dq_out = (w_half == HALF_HI) ? w_wdata[31:16] : w_wdata[15:0];

        // Data stays on the bus one cycle past the WE_N rising edge for hold time.
        w_nxt_dq_oe = (w_phase && w_wr) || (w_cur_phase && r_wr && r_cnt == 4'd0);
        w_nxt_ack   = (w_nxt_state == ACK);

        w_rd_sample = w_cur_phase && !r_wr && (r_cnt == 4'd0);
        w_rd_half   = {(r_state == HI ? r_bmask[3] : r_bmask[1]) ? SRAM_DQ[15:8] : 8'h00,
                       (r_state == HI ? r_bmask[2] : r_bmask[0]) ? SRAM_DQ[7:0]  : 8'h00};
        w_nxt_rbuf  = r_rbuf;
        if (w_accept)                            w_nxt_rbuf = '0;
        else if (w_rd_sample && r_state == HI)   w_nxt_rbuf[31:16] = w_rd_half;
        else if (w_rd_sample)                    w_nxt_rbuf[15:0]  = w_rd_half;
        w_nxt_rdata = (w_nxt_ack && r_state != ACK && !w_wr) ? w_nxt_rbuf : r_rdata;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
            r_rbuf      <= '0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
        end else begin
            r_sram_addr <= w_nxt_addr;
            r_ce_n      <= !w_phase;
            r_we_n      <= !(w_phase && w_wr && (w_nxt_cnt != CNT_LOAD));
            r_oe_n      <= !(w_phase && !w_wr);
            r_lb_n      <= !(w_phase && w_half_mask[0]);
            r_ub_n      <= !(w_phase && w_half_mask[1]);
            r_dq_oe     <= w_nxt_dq_oe;
            r_dq_out    <= w_nxt_dq_out;
            r_rbuf      <= w_nxt_rbuf;
            r_rdata     <= w_nxt_rdata;
            r_ack       <= w_nxt_ack;
        end
    end

    assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'bz;
    assign SRAM_ADDR = r_sram_addr;
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_LB_N = r_lb_n;
    assign SRAM_UB_N = r_ub_n;
    assign o_rdata   = r_rdata;
    assign o_ack     = r_ack;
    assign o_state   = r_state;

endmodule

// File: tb/tb_sram_bridge_32b.sv
// Directed bench for sram_bridge_32b with a behavioural SRAM and queue-based scoreboards
// for both the SRAM write strobes and the LSU acknowledges.
module tb_sram_bridge_32b;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } ack_exp_t;

    logic        i_clk, i_rst;
    logic [17:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_bmask;
    logic        i_wren, i_rden;
    logic [31:0] o_rdata;
    logic        o_ack;
    logic [1:0]  o_state;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N;

    logic [35:0] exp_q[$];
    ack_exp_t    ack_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    int          ce_low_cnt = 0;

    sram_bridge_32b #(.WAIT_CYCLES(2), .ADDR_W(18)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_bmask(i_bmask), .i_wren(i_wren), .i_rden(i_rden),
        .o_rdata(o_rdata), .o_ack(o_ack), .o_state(o_state),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end
    always @(posedge i_clk) cyc <= cyc + 1;

    // behavioural SRAM
    logic [15:0] mem [0:262143];
    logic [15:0] sram_rd;
    assign sram_rd = mem[SRAM_ADDR];
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? sram_rd : 16'bz;
    always @(posedge i_clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
            if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: pin-level write strobes and acknowledges
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                if (!SRAM_CE_N) ce_low_cnt++;
                if (!SRAM_CE_N && !SRAM_WE_N) begin
                    if (exp_q.size() == 0) check("unexpected_we", 64'(SRAM_ADDR), 64'h3ffff);
                    else check("we_strobe", 64'({SRAM_ADDR, SRAM_DQ, SRAM_LB_N, SRAM_UB_N}),
                               64'(exp_q.pop_front()));
                end
                if (o_ack) begin
                    if (ack_q.size() == 0) begin
                        check("unexpected_ack", 64'(o_ack), 64'd0);
                    end else begin
                        ack_exp_t e;
                        e = ack_q.pop_front();
                        check("ack_latency", 64'(cyc - req_cyc), 64'(e.lat));
                        check("ack_rdata", 64'(o_rdata), 64'(e.rdata));
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic push_wr(input logic [17:0] a, input logic [15:0] d, input logic lb_n, input logic ub_n);
        exp_q.push_back({a, d, lb_n, ub_n});
    endtask

    task automatic do_req(input logic wr, input logic rd, input logic [17:0] a, input logic [31:0] wd,
                          input logic [3:0] m, input int lat, input logic [31:0] exp_rd);
        ack_exp_t e;
        bit got;
        @(negedge i_clk);
        i_wren = wr; i_rden = rd; i_addr = a; i_wdata = wd; i_bmask = m;
        e.lat = lat; e.rdata = exp_rd;
        ack_q.push_back(e);
        req_cyc = cyc;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_ack) begin
                got = 1;
                break;
            end
        end
        i_wren = 1'b0; i_rden = 1'b0;
        if (!got) begin
            check("ack_timeout", 64'd0, 64'd1);
            ack_q.delete();
            exp_q.delete();
        end
    endtask

    initial begin
        bit seen_we;
        i_rst = 1'b0; i_addr = '0; i_wdata = '0; i_bmask = '0; i_wren = 1'b0; i_rden = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_ce_n", 64'(SRAM_CE_N), 64'd1);
        check("rst_we_oe_lb_ub", 64'({SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N}), 64'hf);
        check("rst_addr", 64'(SRAM_ADDR), 64'd0);
        check("rst_dq_z", 64'(SRAM_DQ === 16'bz), 64'd1);
        check("rst_rdata", 64'(o_rdata), 64'd0);
        check("rst_ack", 64'(o_ack), 64'd0);
        check("rst_state", 64'(o_state), 64'd0);
        i_rst = 1'b1;

        // full write, then full read back
        push_wr(18'h01002, 16'hBEEF, 1'b0, 1'b0);
        push_wr(18'h01003, 16'hDEAD, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 18'h02004, 32'hDEADBEEF, 4'b1111, 5, 32'h0);
        do_req(1'b0, 1'b1, 18'h02004, 32'h0, 4'b1111, 5, 32'hDEADBEEF);
        repeat (3) @(negedge i_clk);
        check("rdata_hold_idle", 64'(o_rdata), 64'hDEADBEEF);

        // single-byte write into the upper half
        push_wr(18'h01003, 16'h00AB, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 18'h02004, 32'h00AB0000, 4'b0100, 3, 32'hDEADBEEF);
        do_req(1'b0, 1'b1, 18'h02004, 32'h0, 4'b1111, 5, 32'hDEABBEEF);

        // masked read and empty mask
        do_req(1'b0, 1'b1, 18'h02004, 32'h0, 4'b0011, 3, 32'h0000BEEF);
        ce_low_cnt = 0;
        do_req(1'b1, 1'b0, 18'h02004, 32'h0, 4'b0000, 1, 32'h0000BEEF);
        check("empty_mask_ce_idle", 64'(ce_low_cnt), 64'd0);

        // simultaneous request: write wins, read data untouched
        push_wr(18'h00008, 16'h5678, 1'b0, 1'b0);
        push_wr(18'h00009, 16'h1234, 1'b0, 1'b0);
        do_req(1'b1, 1'b1, 18'h00010, 32'h12345678, 4'b1111, 5, 32'h0000BEEF);
        do_req(1'b0, 1'b1, 18'h00010, 32'h0, 4'b1010, 5, 32'h12005600);

        // reset while WE_N is low in the LO phase
        push_wr(18'h00020, 16'hF00D, 1'b0, 1'b0);
        @(negedge i_clk);
        i_wren = 1'b1; i_addr = 18'h00040; i_wdata = 32'hCAFEF00D; i_bmask = 4'b1111;
        seen_we = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (!SRAM_WE_N) begin
                seen_we = 1;
                break;
            end
        end
        check("rst_mid_we_seen", 64'(seen_we), 64'd1);
        #2;
        i_rst = 1'b0; i_wren = 1'b0;
        #1;
        check("rst_mid_we_ce", 64'({SRAM_WE_N, SRAM_CE_N}), 64'h3);
        check("rst_mid_dq_z", 64'(SRAM_DQ === 16'bz), 64'd1);
        check("rst_mid_ack", 64'(o_ack), 64'd0);
        check("rst_mid_wr_q", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("post_rst_state", 64'(o_state), 64'd0);
        check("post_rst_rdata", 64'(o_rdata), 64'd0);
        do_req(1'b0, 1'b1, 18'h02004, 32'h0, 4'b1111, 5, 32'hDEABBEEF);

        repeat (3) @(negedge i_clk);
        check("ack_q_drained", 64'(ack_q.size()), 64'd0);
        check("we_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
